// File: rtl/mini_cpu_pkg.sv
// Shared definitions for the mini_cpu_core slice: instruction field layout,
// opcode values, FSM state encoding and small decode helpers.
package mini_cpu_pkg;

    localparam int OP_LSB  = 0;
    localparam int OP_W    = 6;
    localparam int RD_LSB  = 6;
    localparam int RS_LSB  = 10;
    localparam int IMM_LSB = 14;

    localparam logic [OP_W-1:0] OP_NOP    = 6'd0;
    localparam logic [OP_W-1:0] OP_MOV_RR = 6'd1;
    localparam logic [OP_W-1:0] OP_MOV_RI = 6'd2;
    localparam logic [OP_W-1:0] OP_ADD_RR = 6'd3;
    localparam logic [OP_W-1:0] OP_ADD_RI = 6'd4;
    localparam logic [OP_W-1:0] OP_SUB_RR = 6'd5;
    localparam logic [OP_W-1:0] OP_SUB_RI = 6'd6;
    localparam logic [OP_W-1:0] OP_AND_RR = 6'd7;
    localparam logic [OP_W-1:0] OP_OR_RR  = 6'd8;
    localparam logic [OP_W-1:0] OP_CMP_RR = 6'd9;
    localparam logic [OP_W-1:0] OP_JE     = 6'd10;
    localparam logic [OP_W-1:0] OP_JNE    = 6'd11;
    localparam logic [OP_W-1:0] OP_JMP_R  = 6'd12;
    localparam logic [OP_W-1:0] OP_HALT   = 6'd13;

    typedef enum logic [1:0] {
        ST_IDLE_RST,
        ST_FETCH,
        ST_EXEC,
        ST_HALT
    } state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    // ALU ops and CMP are the only instructions that touch Z/C.
    function automatic logic updates_flags(input logic [OP_W-1:0] op);
        return (op >= OP_ADD_RR) && (op <= OP_CMP_RR);
    endfunction

    function automatic logic uses_imm(input logic [OP_W-1:0] op);
        return (op == OP_MOV_RI) || (op == OP_ADD_RI) || (op == OP_SUB_RI);
    endfunction

    function automatic logic is_illegal(input logic [OP_W-1:0] op);
        return op > OP_HALT;
    endfunction

endpackage

// File: rtl/mini_cpu_alu.sv
// Combinational ALU: computes result, zero/carry and whether rd is written.
// SUB and CMP report borrow in c; AND/OR clear it.
module mini_cpu_alu
    import mini_cpu_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [5:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic              z,
    output logic              c,
    output logic              we
);

    logic [DATA_W:0] sum;
    logic [DATA_W:0] diff;

    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        result = '0;
        c      = 1'b0;
        we     = 1'b0;
        case (op)
            OP_MOV_RR, OP_MOV_RI: begin
                result = b;
                we     = 1'b1;
            end
            OP_ADD_RR, OP_ADD_RI: begin
                result = sum[DATA_W-1:0];
                c      = sum[DATA_W];
                we     = 1'b1;
            end
            OP_SUB_RR, OP_SUB_RI: begin
                result = diff[DATA_W-1:0];
                c      = diff[DATA_W];
                we     = 1'b1;
            end
            OP_AND_RR: begin
                result = a & b;
                we     = 1'b1;
            end
            OP_OR_RR: begin
                result = a | b;
                we     = 1'b1;
            end
            OP_CMP_RR: begin
                result = diff[DATA_W-1:0];
                c      = diff[DATA_W];
            end
            default: ;
        endcase
        z = (result == '0);
    end

endmodule

// File: rtl/mini_cpu_core.sv
// Multi-cycle accumulator-style CPU: req/ack instruction fetch, register file,
// Z/C flags, retire/halt/illegal reporting. Two cycles per instruction plus wait states.
module mini_cpu_core
    import mini_cpu_pkg::*;
#(
    parameter int                DATA_W       = 16,
    parameter int                ADDR_W       = 8,
    parameter int                NREGS        = 4,
    parameter int                INSTR_W      = 24,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               retire,
    output logic [ADDR_W-1:0]  retire_pc,
    output logic               halted,
    output logic               illegal
);

    localparam int REG_IDX_W = clog2(NREGS);
    localparam int IMM_W     = INSTR_W - IMM_LSB;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [INSTR_W-1:0]  instr_q, instr_d;
    logic [DATA_W-1:0]   regs_q [NREGS];
    logic [DATA_W-1:0]   regs_d [NREGS];
    logic                z_q, z_d, c_q, c_d;
    logic                imem_req_q, imem_req_d;
    logic [ADDR_W-1:0]   imem_addr_q, imem_addr_d;
    logic                retire_q, retire_d;
    logic [ADDR_W-1:0]   retire_pc_q, retire_pc_d;
    logic                halted_q, halted_d;
    logic                illegal_q, illegal_d;

    logic [OP_W-1:0]          op;
    logic [REG_IDX_W-1:0]     rd_idx, rs_idx;
    logic signed [IMM_W-1:0]  imm;
    logic [DATA_W-1:0]        rd_val, rs_val, alu_b, alu_result;
    logic                     alu_z, alu_c, alu_we;
    logic [ADDR_W-1:0]        pc_inc, branch_target;
    logic                     unused_instr;

    // Register indices keep only the low bits; extra rd/rs bits are don't-care.
    assign op            = instr_q[OP_LSB +: OP_W];
    assign rd_idx        = instr_q[RD_LSB +: REG_IDX_W];
    assign rs_idx        = instr_q[RS_LSB +: REG_IDX_W];
    assign imm           = instr_q[INSTR_W-1:IMM_LSB];
    assign unused_instr  = ^instr_q;

    assign rd_val        = regs_q[rd_idx];
    assign rs_val        = regs_q[rs_idx];
    assign alu_b         = uses_imm(op) ? DATA_W'(imm) : rs_val;
    assign pc_inc        = pc_q + ADDR_W'(1);
    assign branch_target = pc_inc + ADDR_W'(imm);

    mini_cpu_alu #(.DATA_W(DATA_W)) u_alu (
        .op     (op),
        .a      (rd_val),
        .b      (alu_b),
        .result (alu_result),
        .z      (alu_z),
        .c      (alu_c),
        .we     (alu_we)
    );

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        regs_d      = regs_q;
        z_d         = z_q;
        c_d         = c_q;
        imem_req_d  = imem_req_q;
        imem_addr_d = imem_addr_q;
        retire_d    = 1'b0;
        retire_pc_d = retire_pc_q;
        halted_d    = halted_q;
        illegal_d   = 1'b0;

        case (state_q)
            ST_IDLE_RST: begin
                state_d     = ST_FETCH;
                imem_req_d  = 1'b1;
                imem_addr_d = pc_q;
            end
            ST_FETCH: begin
                if (imem_ack) begin
                    instr_d    = imem_rdata;
                    state_d    = ST_EXEC;
                    imem_req_d = 1'b0;
                end
            end
            ST_EXEC: begin
                retire_d    = 1'b1;
                retire_pc_d = pc_q;
                pc_d        = pc_inc;
                case (op)
                    OP_JE:    if (z_q)  pc_d = branch_target;
                    OP_JNE:   if (!z_q) pc_d = branch_target;
                    OP_JMP_R: pc_d = ADDR_W'(rs_val);
                    default: ;
                endcase

                if (is_illegal(op)) begin
                    illegal_d = 1'b1;
                    pc_d      = RESET_VECTOR;
                end else begin
                    if (alu_we) regs_d[rd_idx] = alu_result;
                    if (updates_flags(op)) begin
                        z_d = alu_z;
                        c_d = alu_c;
                    end
                end

                if (op == OP_HALT) begin
                    state_d  = ST_HALT;
                    halted_d = 1'b1;
                end else begin
                    state_d     = ST_FETCH;
                    imem_req_d  = 1'b1;
                    imem_addr_d = pc_d;
                end
            end
            ST_HALT: ;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE_RST;
            pc_q        <= RESET_VECTOR;
            instr_q     <= '0;
            z_q         <= 1'b0;
            c_q         <= 1'b0;
            imem_req_q  <= 1'b0;
            imem_addr_q <= RESET_VECTOR;
            retire_q    <= 1'b0;
            retire_pc_q <= '0;
            halted_q    <= 1'b0;
            illegal_q   <= 1'b0;
            // NOTE: the register file is architecturally zero after reset, so it is reset here.
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            z_q         <= z_d;
            c_q         <= c_d;
            imem_req_q  <= imem_req_d;
            imem_addr_q <= imem_addr_d;
            retire_q    <= retire_d;
            retire_pc_q <= retire_pc_d;
            halted_q    <= halted_d;
            illegal_q   <= illegal_d;
            regs_q      <= regs_d;
        end
    end

    assign imem_req  = imem_req_q;
    assign imem_addr = imem_addr_q;
    assign retire    = retire_q;
    assign retire_pc = retire_pc_q;
    assign halted    = halted_q;
    assign illegal   = illegal_q;

endmodule
